rvfi_progress_monitor: RTL

//  Parametrised liveness checker for the minrv32 formal/sim benches. It sits beside the core.
//  It watches the memory handshake and the RVFI retirement stream, and requires NRET retirements
//  of an expected instruction within TIMEOUT cycles of reset release.
//  It also flags memory-side fairness violations. The bench turns those into assumptions, and the

---
 rtl/rvfi_progress_monitor.sv | 114 +++++++++++
 1 files changed

// File: rtl/rvfi_progress_monitor.sv
// Liveness monitor for the minrv32 benches: requires NRET retirements of exp_insn
// within TIMEOUT cycles of reset release, and tracks memory-side stall fairness.
module rvfi_progress_monitor #(
  parameter int unsigned TIMEOUT    = 21,
  parameter int unsigned NRET       = 1,
  parameter int unsigned MAX_STALL  = 1,
  parameter bit          COMPRESSED = 1'b1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             mem_valid,
  input  logic             mem_ready,
  input  logic             rvfi_valid,
  input  logic [31:0]      rvfi_insn,
  input  logic [31:0]      exp_insn,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic             fair_ok,
  output logic             mismatch,
  output logic [7:0]       match_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam logic [7:0]       NRET_C      = 8'(NRET);
  localparam logic [CNT_W:0]   MAX_STALL_C = (CNT_W+1)'(MAX_STALL);

  state_t           state_q, state_d;
  logic             insn_eq;
  logic             hit;
  logic             stalled;
  logic [CNT_W-1:0] cycle_d;
  logic [7:0]       match_d;
  logic             mismatch_d;
  logic [CNT_W-1:0] stall_cnt, stall_d;
  logic [CNT_W:0]   stall_inc;
  logic             fair_d;

  // A compressed expected word only constrains the low halfword of the retired word.
  always_comb begin
    insn_eq = (rvfi_insn == exp_insn);
    if (COMPRESSED && (exp_insn[1:0] != 2'b11)) begin
      insn_eq = (rvfi_insn[15:0] == exp_insn[15:0]);
    end
  end

  assign hit = rvfi_valid && insn_eq;

  always_comb begin
    state_d    = state_q;
    cycle_d    = cycle_count;
    match_d    = match_count;
    mismatch_d = mismatch;
    unique case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN: begin
        if (cycle_count != TIMEOUT_C) cycle_d = cycle_count + CNT_ONE;
        if (rvfi_valid && !insn_eq) mismatch_d = 1'b1;
        if (hit && (match_count != NRET_C)) match_d = match_count + 8'd1;
        // The final retirement takes priority over a coincident timeout.
        if (hit && ((match_count + 8'd1) == NRET_C)) begin
          state_d = ST_DONE;
        end else if ((cycle_count + CNT_ONE) == TIMEOUT_C) begin
          state_d = ST_FAIL;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    stalled   = mem_valid && !mem_ready;
    stall_inc = {1'b0, stall_cnt} + {{CNT_W{1'b0}}, 1'b1};
    stall_d   = '0;
    fair_d    = fair_ok;
    if (stalled) begin
      stall_d = (stall_cnt == '1) ? stall_cnt : stall_inc[CNT_W-1:0];
      if (stall_inc > MAX_STALL_C) fair_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cycle_count <= '0;
      match_count <= '0;
      mismatch    <= 1'b0;
      stall_cnt   <= '0;
      fair_ok     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cycle_count <= cycle_d;
      match_count <= match_d;
      mismatch    <= mismatch_d;
      stall_cnt   <= stall_d;
      fair_ok     <= fair_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign fail = (state_q == ST_FAIL);

endmodule
